// File: rtl/perm_comb_pkg.sv
// perm_comb_pkg: shared states, mode codes and default widths for the nPr/nCr engine
package perm_comb_pkg;
  localparam int DEF_IN_W = 8;
  localparam int DEF_OUT_W = 32;
  localparam logic MODE_NPR = 1'b0;
  localparam logic MODE_NCR = 1'b1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/perm_comb_step.sv
// perm_comb_step: one iteration, acc*(n-k) optionally divided by (k+1), with saturation check
module perm_comb_step import perm_comb_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [OUT_W-1:0] acc_i,
  input  logic [IN_W-1:0]  nk_i,
  input  logic [IN_W:0]    k1_i,
  input  logic             mode_i,
  output logic [OUT_W-1:0] q_o,
  output logic             ovf_o
);
  logic [OUT_W+IN_W-1:0] p, q;
  assign p = {{IN_W{1'b0}}, acc_i} * {{OUT_W{1'b0}}, nk_i};
  // nCr divide is exact: the running product is always a binomial times k+1
  assign q = (mode_i == MODE_NCR) ? p / {{(OUT_W-1){1'b0}}, k1_i} : p;
  assign q_o = q[OUT_W-1:0];
  assign ovf_o = |q[OUT_W+IN_W-1:OUT_W];
endmodule

// File: rtl/perm_comb_seq.sv
// perm_comb_seq: sequential nPr / nCr engine, one factor per clock with start/busy/done handshake
module perm_comb_seq import perm_comb_pkg::*; #(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IN_W-1:0]  n,
  input  logic [IN_W-1:0]  r,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic             err
);
  state_e state_q, state_d;
  logic mode_q, mode_d, ovf_q, ovf_d, err_q, err_d;
  logic [IN_W-1:0] n_q, n_d, m_q, m_d, k_q, k_d, nr, m_new;
  logic [OUT_W-1:0] acc_q, acc_d, res_q, res_d, q;
  logic [IN_W:0] k1;
  logic q_ovf, bad;
  assign nr = n - r;
  assign bad = r > n;
  assign m_new = (mode == MODE_NCR && nr < r) ? nr : r;
  assign k1 = {1'b0, k_q} + {{IN_W{1'b0}}, 1'b1};
  perm_comb_step #(.IN_W(IN_W), .OUT_W(OUT_W)) u_step (
    .acc_i(acc_q), .nk_i(n_q - k_q), .k1_i(k1), .mode_i(mode_q), .q_o(q), .ovf_o(q_ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      n_q <= '0;
      m_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      n_q <= n_d;
      m_q <= m_d;
      k_q <= k_d;
      acc_q <= acc_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    n_d = n_q;
    m_d = m_q;
    k_d = k_q;
    acc_d = acc_q;
    res_d = res_q;
    ovf_d = ovf_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        n_d = n;
        m_d = m_new;
        k_d = '0;
        acc_d = OUT_W'(1);
        ovf_d = 1'b0;
        err_d = bad;
        res_d = (!bad && m_new == '0) ? OUT_W'(1) : '0;
        state_d = (bad || m_new == '0) ? DONE : CALC;
      end
      CALC: if (q_ovf) begin
        res_d = '1;
        ovf_d = 1'b1;
        state_d = DONE;
      end else begin
        acc_d = q;
        k_d = k1[IN_W-1:0];
        if (k1 == {1'b0, m_q}) begin
          res_d = q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q == CALC;
    done = state_q == DONE;
  end
  assign result = res_q;
  assign overflow = ovf_q;
  assign err = err_q;
endmodule

// File: tb/tb_perm_comb_seq.sv
// tb_perm_comb_seq: scoreboard bench for the nPr/nCr engine against a wide-arithmetic reference
module tb_perm_comb_seq;
  typedef struct {
    logic [31:0] res;
    logic ovf;
    logic err;
    int lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [7:0] n = '0, r = '0;
  logic busy, done, overflow, err;
  logic [31:0] result;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  perm_comb_seq #(.IN_W(8), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n(n), .r(r),
    .busy(busy), .done(done), .result(result), .overflow(overflow), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input bit md, input int nn, input int rr);
    exp_t e;
    longint unsigned acc, p;
    int m;
    e.res = 0; e.ovf = 0; e.err = 0; e.lat = 1;
    if (rr > nn) begin
      e.err = 1;
      return e;
    end
    m = (md && nn - rr < rr) ? nn - rr : rr;
    if (m == 0) begin
      e.res = 1;
      return e;
    end
    acc = 1;
    for (int k = 0; k < m; k++) begin
      p = acc * longint'(nn - k);
      if (md) p = p / longint'(k + 1);
      if (p > 64'hFFFF_FFFF) begin
        e.res = '1; e.ovf = 1; e.lat = k + 2;
        return e;
      end
      acc = p;
    end
    e.res = acc[31:0];
    e.lat = m + 1;
    return e;
  endfunction
  // poke pulses a foreign start mid-CALC which must be ignored
  task automatic run(input string tag, input bit md, input int nn, input int rr, input bit poke);
    exp_t e;
    int cyc, bcnt;
    sb.push_back(model(md, nn, rr));
    @(negedge clk);
    start = 1'b1; mode = md; n = 8'(nn); r = 8'(rr);
    @(negedge clk);
    start = 1'b0; mode = ~md; n = 8'd200; r = 8'd1;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 300) begin
      bcnt += int'(busy);
      start = poke && cyc == 2;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_busy"}, 64'(bcnt), 64'(e.lat - 1));
    chk({tag, "_res"}, 64'(result), 64'(e.res));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
    chk({tag, "_err"}, 64'(err), 64'(e.err));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'({done, busy}), 0);
    chk({tag, "_hold"}, 64'({result, overflow, err}), 64'({e.res, e.ovf, e.err}));
  endtask
  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'({busy, done, result, overflow, err}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out", 64'({busy, done, result, overflow, err}), 0);
    run("npr5_2", 0, 5, 2, 0);
    chk("npr5_2_val", 64'(result), 20);
    run("ncr10_7", 1, 10, 7, 0);
    chk("ncr10_7_val", 64'(result), 120);
    run("ncr10_3", 1, 10, 3, 0);
    chk("ncr10_3_val", 64'(result), 120);
    run("ncr8_8", 1, 8, 8, 0);
    run("npr0_0", 0, 0, 0, 0);
    run("err3_5", 0, 3, 5, 0);
    run("after_err", 0, 4, 1, 0);
    run("npr12", 0, 12, 12, 0);
    chk("npr12_val", 64'(result), 479001600);
    run("npr13", 0, 13, 13, 0);
    chk("npr13_val", 64'({overflow, result}), 64'h1_FFFF_FFFF);
    run("poke", 1, 20, 9, 1);
    run("ncr34_17", 1, 34, 17, 0);
    run("ncr40_20", 1, 40, 20, 0);
    // reset during CALC: outputs clear at once and no done follows
    @(negedge clk);
    start = 1'b1; mode = 1'b0; n = 8'd12; r = 8'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", 64'({busy, done, result, overflow, err}), 0);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    chk("rst_no_done", 64'(seen), 0);
    run("post_rst", 1, 6, 2, 0);
    for (int i = 0; i < 20; i++)
      run("rand", 1'($urandom_range(1)), int'($urandom_range(24)), int'($urandom_range(26)), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
